// File: rtl/mem_access_stage_pkg.sv
// Shared widths, timeout limit, FSM state encoding and MEM/WB payload for the
// memory-access pipeline stage.
package mem_access_stage_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned REGIDX_W = 5;
  localparam int unsigned TIMEOUT  = 255;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic [XLEN-1:0]     read_data;
    logic [XLEN-1:0]     result;
    logic [REGIDX_W-1:0] inst2;
    logic                memtoreg;
    logic                regwrite;
  } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports: clk, rst_n (async active-low), load_en (capture d), bubble (clear to
// all-zero, wins over load_en), d (next payload), q (registered payload).
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_en,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  memwb_t data_q, data_d;

  // Bubble takes priority so a stalled or aborted op never writes back.
  always_comb begin : next_data
    data_d = data_q;
    if (bubble) begin
      data_d = '0;
    end else if (load_en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests, stalls upstream
// until acknowledged (or until a timeout aborts the op), drives the branch
// redirect and feeds the MEM/WB register.
// Ports: clk, reset (async active-low); EXMEM_* pipeline inputs; dmem_req/we/
// addr/wdata request and dmem_ack/rdata response; PCSrc/branch_target redirect;
// stall to upstream; MEMWB_* register outputs; mem_err sticky timeout flag.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     EXMEM_Result,
  input  logic [XLEN-1:0]     EXMEM_ReadData2,
  input  logic [XLEN-1:0]     EXMEM_out,
  input  logic                EXMEM_ZERO,
  input  logic [REGIDX_W-1:0] EXMEM_inst2,
  input  logic                EXMEM_Branch,
  input  logic                EXMEM_MemRead,
  input  logic                EXMEM_MemtoReg,
  input  logic                EXMEM_MemWrite,
  input  logic                EXMEM_Regwrite,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_ack,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                PCSrc,
  output logic [XLEN-1:0]     branch_target,
  output logic                stall,
  output logic [XLEN-1:0]     MEMWB_ReadData,
  output logic [XLEN-1:0]     MEMWB_Result,
  output logic [REGIDX_W-1:0] MEMWB_inst2,
  output logic                MEMWB_MemtoReg,
  output logic                MEMWB_Regwrite,
  output logic                mem_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             mem_op;
  logic             is_read;
  logic             timeout;
  memwb_t           wb_d, wb_q;

  // Write wins when both control bits are set.
  assign mem_op  = EXMEM_MemRead | EXMEM_MemWrite;
  assign is_read = EXMEM_MemRead & ~EXMEM_MemWrite;

  // Next state, WAIT counter, sticky error and request.
  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    dmem_req  = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req = mem_op;
        if (mem_op && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          // Abort once the count would reach TIMEOUT: the IDLE request cycle
          // plus the preceding WAIT cycles give TIMEOUT stalled cycles.
          timeout   = 1'b1;
          state_d   = IDLE;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    // Reset silences the request even though the inputs may show a memory op.
    if (!reset) begin
      dmem_req = 1'b0;
      timeout  = 1'b0;
    end
  end

  // Request qualifiers, stall and branch redirect.
  always_comb begin : req_outputs
    dmem_we = dmem_req & EXMEM_MemWrite;
    stall   = dmem_req & ~dmem_ack & ~timeout;
    PCSrc   = EXMEM_Branch & EXMEM_ZERO & ~stall;
  end

  assign dmem_addr     = EXMEM_Result;
  assign dmem_wdata    = EXMEM_ReadData2;
  assign branch_target = EXMEM_out;

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  // Payload presented to MEM/WB when the instruction completes.
  always_comb begin : wb_payload
    wb_d           = '0;
    wb_d.result    = EXMEM_Result;
    wb_d.inst2     = EXMEM_inst2;
    wb_d.memtoreg  = EXMEM_MemtoReg;
    wb_d.regwrite  = EXMEM_Regwrite;
    wb_d.read_data = is_read ? dmem_rdata : '0;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst_n   (reset),
    .load_en (~stall),
    .bubble  (stall | timeout),
    .d       (wb_d),
    .q       (wb_q)
  );

  assign MEMWB_ReadData = wb_q.read_data;
  assign MEMWB_Result   = wb_q.result;
  assign MEMWB_inst2    = wb_q.inst2;
  assign MEMWB_MemtoReg = wb_q.memtoreg;
  assign MEMWB_Regwrite = wb_q.regwrite;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a transaction-level reference model.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n = 1'b1;
  logic [63:0] EXMEM_Result, EXMEM_ReadData2, EXMEM_out;
  logic        EXMEM_ZERO;
  logic [4:0]  EXMEM_inst2;
  logic        EXMEM_Branch, EXMEM_MemRead, EXMEM_MemtoReg, EXMEM_MemWrite, EXMEM_Regwrite;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        PCSrc, stall, mem_err;
  logic [63:0] branch_target, MEMWB_ReadData, MEMWB_Result;
  logic [4:0]  MEMWB_inst2;
  logic        MEMWB_MemtoReg, MEMWB_Regwrite;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  mem_access_stage dut (
    .clk(clk), .reset(rst_n),
    .EXMEM_Result(EXMEM_Result), .EXMEM_ReadData2(EXMEM_ReadData2),
    .EXMEM_out(EXMEM_out), .EXMEM_ZERO(EXMEM_ZERO), .EXMEM_inst2(EXMEM_inst2),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_MemtoReg(EXMEM_MemtoReg), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_Regwrite(EXMEM_Regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .PCSrc(PCSrc), .branch_target(branch_target), .stall(stall),
    .MEMWB_ReadData(MEMWB_ReadData), .MEMWB_Result(MEMWB_Result),
    .MEMWB_inst2(MEMWB_inst2), .MEMWB_MemtoReg(MEMWB_MemtoReg),
    .MEMWB_Regwrite(MEMWB_Regwrite), .mem_err(mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction that needs memory stalls each cycle it is
  // not acknowledged; after 255 stalled cycles the next cycle drops it.
  int          m_pending;
  logic        m_err;
  logic [63:0] m_rdata, m_result;
  logic [4:0]  m_inst2;
  logic        m_m2r, m_rw;
  logic        e_req, e_abort, e_stall;

  always_comb begin
    e_req   = rst_n && (EXMEM_MemRead || EXMEM_MemWrite || m_pending != 0);
    e_abort = e_req && !dmem_ack && (m_pending == 255);
    e_stall = e_req && !dmem_ack && !e_abort;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 0; m_err <= 1'b0;
      m_rdata <= '0; m_result <= '0; m_inst2 <= '0; m_m2r <= 1'b0; m_rw <= 1'b0;
    end else begin
      m_pending <= e_stall ? m_pending + 1 : 0;
      if (e_abort) m_err <= 1'b1;
      if (e_stall || e_abort) begin
        m_rdata <= '0; m_result <= '0; m_inst2 <= '0; m_m2r <= 1'b0; m_rw <= 1'b0;
      end else begin
        m_result <= EXMEM_Result;
        m_inst2  <= EXMEM_inst2;
        m_m2r    <= EXMEM_MemtoReg;
        m_rw     <= EXMEM_Regwrite;
        m_rdata  <= (EXMEM_MemRead && !EXMEM_MemWrite) ? dmem_rdata : 64'h0;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", 64'(dmem_req), 64'(e_req));
      chk("dmem_we", 64'(dmem_we), 64'(e_req && EXMEM_MemWrite));
      chk("stall", 64'(stall), 64'(e_stall));
      chk("PCSrc", 64'(PCSrc), 64'(EXMEM_Branch && EXMEM_ZERO && !e_stall));
      chk("branch_target", branch_target, EXMEM_out);
      chk("dmem_addr", dmem_addr, EXMEM_Result);
      chk("dmem_wdata", dmem_wdata, EXMEM_ReadData2);
      chk("MEMWB_ReadData", MEMWB_ReadData, m_rdata);
      chk("MEMWB_Result", MEMWB_Result, m_result);
      chk("MEMWB_inst2", 64'(MEMWB_inst2), 64'(m_inst2));
      chk("MEMWB_MemtoReg", 64'(MEMWB_MemtoReg), 64'(m_m2r));
      chk("MEMWB_Regwrite", 64'(MEMWB_Regwrite), 64'(m_rw));
      chk("mem_err", 64'(mem_err), 64'(m_err));
    end
  end

  task automatic set_nop();
    EXMEM_Result = '0; EXMEM_ReadData2 = '0; EXMEM_out = '0; EXMEM_ZERO = 1'b0;
    EXMEM_inst2 = '0; EXMEM_Branch = 1'b0; EXMEM_MemRead = 1'b0; EXMEM_MemtoReg = 1'b0;
    EXMEM_MemWrite = 1'b0; EXMEM_Regwrite = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    set_nop();
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_MEMWB_Result", MEMWB_Result, 64'h0);
    chk("rst_MEMWB_Regwrite", 64'(MEMWB_Regwrite), 64'h0);
    chk("rst_mem_err", 64'(mem_err), 64'h0);
    // Memory op visible during reset must not raise a request.
    EXMEM_MemRead = 1'b1;
    #1;
    chk("rst_dmem_req", 64'(dmem_req), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    tick();
    set_nop();
    rst_n = 1'b1;

    // ALU op
    EXMEM_Regwrite = 1'b1; EXMEM_Result = 64'h10; EXMEM_inst2 = 5'd5;
    #1;
    chk("alu_stall", 64'(stall), 64'h0);
    chk("alu_req", 64'(dmem_req), 64'h0);
    tick();
    chk("alu_wb_result", MEMWB_Result, 64'h10);
    chk("alu_wb_inst2", 64'(MEMWB_inst2), 64'd5);
    chk("alu_wb_rw", 64'(MEMWB_Regwrite), 64'h1);

    // Load with immediate ack
    set_nop();
    EXMEM_MemRead = 1'b1; EXMEM_MemtoReg = 1'b1; EXMEM_Regwrite = 1'b1;
    EXMEM_Result = 64'h100; EXMEM_inst2 = 5'd3; dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
    #1;
    chk("ld_req", 64'(dmem_req), 64'h1);
    chk("ld_stall", 64'(stall), 64'h0);
    tick();
    chk("ld_wb_rdata", MEMWB_ReadData, 64'hDEAD);

    // Store with ack after three stalled cycles
    set_nop();
    EXMEM_MemWrite = 1'b1; EXMEM_Result = 64'h200; EXMEM_ReadData2 = 64'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", 64'(stall), 64'h1);
      chk("st_we", 64'(dmem_we), 64'h1);
      chk("st_addr", dmem_addr, 64'h200);
      chk("st_wdata", dmem_wdata, 64'hBEEF);
      tick();
      chk("st_wb_rw", 64'(MEMWB_Regwrite), 64'h0);
    end
    dmem_ack = 1'b1;
    #1;
    chk("st_ack_stall", 64'(stall), 64'h0);
    chk("st_ack_we", 64'(dmem_we), 64'h1);
    tick();
    set_nop();
    #1;
    chk("st_idle_req", 64'(dmem_req), 64'h0);
    tick();

    // Read and write both set: treated as a write, no read data
    EXMEM_MemRead = 1'b1; EXMEM_MemWrite = 1'b1; EXMEM_Result = 64'h280;
    dmem_ack = 1'b1; dmem_rdata = 64'h55;
    #1;
    chk("rw_we", 64'(dmem_we), 64'h1);
    tick();
    chk("rw_wb_rdata", MEMWB_ReadData, 64'h0);

    // Branch redirect
    set_nop();
    EXMEM_Branch = 1'b1; EXMEM_ZERO = 1'b1; EXMEM_out = 64'h400;
    #1;
    chk("br_taken", 64'(PCSrc), 64'h1);
    chk("br_target", branch_target, 64'h400);
    EXMEM_ZERO = 1'b0;
    #1;
    chk("br_not_taken", 64'(PCSrc), 64'h0);
    tick();

    // Timeout: load never acknowledged
    set_nop();
    EXMEM_MemRead = 1'b1; EXMEM_Regwrite = 1'b1; EXMEM_Result = 64'h300; EXMEM_inst2 = 5'd7;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!stall) break;
      n++;
      tick();
    end
    chk("to_stall_cycles", 64'(n), 64'd255);
    chk("to_abort_err_before", 64'(mem_err), 64'h0);
    tick();
    chk("to_err", 64'(mem_err), 64'h1);
    chk("to_wb_result", MEMWB_Result, 64'h0);
    chk("to_wb_rw", 64'(MEMWB_Regwrite), 64'h0);
    set_nop();
    repeat (3) tick();
    chk("to_err_sticky", 64'(mem_err), 64'h1);

    // Reset during WAIT
    EXMEM_MemRead = 1'b1; EXMEM_Regwrite = 1'b1; EXMEM_Result = 64'h500;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rst_req", 64'(dmem_req), 64'h0);
    chk("rw_rst_stall", 64'(stall), 64'h0);
    chk("rw_rst_err", 64'(mem_err), 64'h0);
    chk("rw_rst_wb_rw", 64'(MEMWB_Regwrite), 64'h0);
    set_nop();
    tick();
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("stray_ack_req", 64'(dmem_req), 64'h0);
    chk("stray_ack_stall", 64'(stall), 64'h0);
    tick();
    dmem_ack = 1'b0;
    // New load after reset: one stalled cycle, then ack completes it
    EXMEM_MemRead = 1'b1; EXMEM_Regwrite = 1'b1; EXMEM_Result = 64'h600;
    EXMEM_inst2 = 5'd9; dmem_rdata = 64'h1234;
    #1;
    chk("post_rst_stall", 64'(stall), 64'h1);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("post_rst_ack_stall", 64'(stall), 64'h0);
    tick();
    chk("post_rst_wb_rdata", MEMWB_ReadData, 64'h1234);
    chk("post_rst_wb_inst2", 64'(MEMWB_inst2), 64'd9);
    set_nop();
    repeat (2) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
